// File: rtl/unary_pkg.sv
// Shared types and constants for the multi-channel unary stream generator.
// Holds the FSM state type, stream length helper and LFSR tap masks.
package unary_pkg;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  function automatic int stream_len(input int w);
    return 1 << w;
  endfunction

  localparam logic [7:0] TAPS_W4 = 8'h0C;
  localparam logic [7:0] TAPS_W5 = 8'h14;
  localparam logic [7:0] TAPS_W6 = 8'h30;
  localparam logic [7:0] TAPS_W7 = 8'h60;
  localparam logic [7:0] TAPS_W8 = 8'hB8;

  // Fibonacci feedback masks for maximal-length sequences
  function automatic logic [7:0] lfsr_taps(input int w);
    case (w)
      5:       return TAPS_W5;
      6:       return TAPS_W6;
      7:       return TAPS_W7;
      8:       return TAPS_W8;
      default: return TAPS_W4;
    endcase
  endfunction

endpackage

// File: rtl/unary_lane.sv
// One channel: value latch, unary comparator and LEN-bit shift register.
// STOCH_LFSR_EN adds the stochastic comparison against a shared LFSR.
import unary_pkg::*;

module unary_lane #(
  parameter int W = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    load,
  input  logic                    run,
  input  logic                    fin,
  input  logic                    mode,
  input  logic [W-1:0]            cnt,
  input  logic [W-1:0]            val,
`ifdef STOCH_LFSR_EN
  input  logic                    stoch,
  input  logic [W-1:0]            lfsr,
`endif
  output logic                    ubit,
  output logic [stream_len(W)-1:0] par
);

  localparam int LEN = stream_len(W);
  localparam logic [W:0] LENV = (W+1)'(LEN);

  logic [W-1:0]   v_q;
  logic [LEN-1:0] shreg;
  logic [W:0]     thr;
  logic           b;

  // Threshold kept W+1 bits wide so v=0 yields no ones when right-aligned
  always_comb begin
    thr = LENV - {1'b0, v_q};
    b   = mode ? ({1'b0, cnt} >= thr) : (cnt < v_q);
`ifdef STOCH_LFSR_EN
    if (stoch) b = (lfsr < v_q);
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      v_q   <= '0;
      shreg <= '0;
      ubit  <= 1'b0;
      par   <= '0;
    end else if (load) begin
      v_q   <= val;
      shreg <= '0;
      ubit  <= 1'b0;
      par   <= '0;
    end else if (run) begin
      ubit  <= b;
      shreg <= {shreg[LEN-2:0], b};
    end else begin
      ubit <= 1'b0;
      if (fin) par <= shreg;
    end
  end

endmodule

// File: rtl/unary_stream_gen.sv
// Multi-channel unary bitstream generator with start/busy/done handshake.
// Optional STOCH_LFSR_EN adds a stoch input and an LFSR-driven stochastic mode.
import unary_pkg::*;

module unary_stream_gen #(
  parameter int CH        = 4,
  parameter int W         = 4,
  parameter int LFSR_SEED = 1
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         start,
  input  logic                         mode,
  input  logic [CH*W-1:0]              vals,
`ifdef STOCH_LFSR_EN
  input  logic                         stoch,
`endif
  output logic                         busy,
  output logic                         bit_valid,
  output logic [CH-1:0]                bits,
  output logic                         done,
  output logic [CH*stream_len(W)-1:0]  par_out
);

  localparam int LEN = stream_len(W);

  if ((LFSR_SEED % LEN) == 0) begin : g_seed_chk
    $error("LFSR_SEED must be non-zero in W bits");
  end

  state_t       state, state_nx;
  logic [W-1:0] cnt;
  logic         mode_q;
  logic         accept, run, fin;

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:    if (start) state_nx = RUN;
      RUN:     if (cnt == '1) state_nx = DONE;
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    busy   = (state != IDLE);
    run    = (state == RUN);
    fin    = (state == DONE);
    accept = (state == IDLE) && start;
  end

  // cnt wraps to zero on the final RUN edge
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt       <= '0;
      mode_q    <= 1'b0;
      bit_valid <= 1'b0;
      done      <= 1'b0;
    end else begin
      bit_valid <= run;
      done      <= fin;
      if (accept) begin
        cnt    <= '0;
        mode_q <= mode;
      end else if (run) begin
        cnt <= cnt + 1'b1;
      end
    end
  end

`ifdef STOCH_LFSR_EN
  localparam logic [7:0] TAPS = lfsr_taps(W);

  logic [W-1:0] lfsr;
  logic         stoch_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      lfsr    <= '0;
      stoch_q <= 1'b0;
    end else if (accept) begin
      lfsr    <= W'(LFSR_SEED);
      stoch_q <= stoch;
    end else if (run) begin
      lfsr <= {lfsr[W-2:0], ^(lfsr & TAPS[W-1:0])};
    end
  end
`endif

  for (genvar c = 0; c < CH; c++) begin : g_lane
    unary_lane #(.W(W)) u_lane (
      .clk   (clk),
      .rst   (rst),
      .load  (accept),
      .run   (run),
      .fin   (fin),
      .mode  (mode_q),
      .cnt   (cnt),
      .val   (vals[c*W +: W]),
`ifdef STOCH_LFSR_EN
      .stoch (stoch_q),
      .lfsr  (lfsr),
`endif
      .ubit  (bits[c]),
      .par   (par_out[c*LEN +: LEN])
    );
  end

endmodule

// File: tb/tb_unary_stream_gen.sv
// Self-checking bench for unary_stream_gen against an arithmetic word model.
// Covers STOCH_LFSR_EN when that macro is defined for the build.
module tb_unary_stream_gen;

  localparam int CH  = 4;
  localparam int W   = 4;
  localparam int LEN = 1 << W;

  logic                clk = 1'b0;
  logic                rst = 1'b1;
  logic                start = 1'b0;
  logic                mode = 1'b0;
  logic [CH*W-1:0]     vals = '0;
  logic                busy, bit_valid, done;
  logic [CH-1:0]       bits;
  logic [CH*LEN-1:0]   par_out;
`ifdef STOCH_LFSR_EN
  logic                stoch = 1'b0;
`endif

  int n_assert = 0;
  int n_fail   = 0;

  unary_stream_gen #(.CH(CH), .W(W), .LFSR_SEED(1)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .mode      (mode),
    .vals      (vals),
`ifdef STOCH_LFSR_EN
    .stoch     (stoch),
`endif
    .busy      (busy),
    .bit_valid (bit_valid),
    .bits      (bits),
    .done      (done),
    .par_out   (par_out)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [127:0] obs,
                     input logic [127:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // v ones packed at the top (ones first) or bottom (ones last)
  function automatic logic [LEN-1:0] exp_word(input int v, input bit m);
    longint ones;
    ones = (longint'(1) << v) - 1;
    if (m) return LEN'(ones);
    return LEN'(ones << (LEN - v));
  endfunction

  task automatic run_stream(input logic [CH*W-1:0] v, input bit m,
                            input bit hold, input bit scramble);
    logic [LEN-1:0]    w [CH];
    logic [LEN-1:0]    tmp;
    logic [CH-1:0]     eb;
    logic [CH*LEN-1:0] ep;
    for (int c = 0; c < CH; c++) begin
      w[c] = exp_word(int'(v[c*W +: W]), m);
      ep[c*LEN +: LEN] = w[c];
    end
    start = 1'b1;
    vals  = v;
    mode  = m;
    step();
    if (!hold) start = 1'b0;
    chk("accept_busy", busy, 1);
    chk("accept_par_clear", par_out, 0);
    chk("accept_done", done, 0);
    if (scramble) begin
      vals = CH*W'($urandom);
      mode = ~m;
    end
    for (int i = 0; i < LEN; i++) begin
      step();
      for (int c = 0; c < CH; c++) begin
        tmp = w[c];
        eb[c] = tmp[LEN-1-i];
      end
      chk("bits", bits, eb);
      chk("bit_valid_run", bit_valid, 1);
      chk("busy_run", busy, 1);
      chk("done_run", done, 0);
    end
    step();
    chk("done_pulse", done, 1);
    chk("bit_valid_end", bit_valid, 0);
    chk("busy_end", busy, 0);
    chk("par_out", par_out, ep);
    if (!hold) begin
      step();
      chk("done_clear", done, 0);
      chk("par_hold", par_out, ep);
    end
  endtask

  bit saw_done;

  initial begin
    rst = 1'b1;
    step();
    step();
    chk("rst_busy", busy, 0);
    chk("rst_valid", bit_valid, 0);
    chk("rst_bits", bits, 0);
    chk("rst_done", done, 0);
    chk("rst_par", par_out, 0);
    rst = 1'b0;
    step();

    run_stream({4'd15, 4'd0, 4'd8, 4'd3}, 1'b0, 1'b0, 1'b0);
    run_stream({4'd15, 4'd0, 4'd8, 4'd3}, 1'b1, 1'b0, 1'b0);
    run_stream({4'd1, 4'd14, 4'd2, 4'd7}, 1'b1, 1'b0, 1'b1);

    run_stream(CH*W'($urandom), 1'b0, 1'b1, 1'b0);
    run_stream(CH*W'($urandom), 1'b1, 1'b1, 1'b0);
    run_stream(CH*W'($urandom), 1'b0, 1'b0, 1'b0);

    start = 1'b1;
    vals  = {4'd9, 4'd9, 4'd9, 4'd9};
    mode  = 1'b0;
    step();
    start = 1'b0;
    for (int i = 0; i < 5; i++) step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("midrst_busy", busy, 0);
    chk("midrst_bits", bits, 0);
    chk("midrst_valid", bit_valid, 0);
    chk("midrst_par", par_out, 0);
    saw_done = 1'b0;
    for (int i = 0; i < LEN + 3; i++) begin
      if (done) saw_done = 1'b1;
      step();
    end
    chk("midrst_no_done", saw_done, 0);

    for (int r = 0; r < 6; r++)
      run_stream(CH*W'($urandom), 1'($urandom), 1'b0, 1'($urandom));

`ifdef STOCH_LFSR_EN
    begin
      int seq [15] = '{1, 2, 4, 9, 3, 6, 13, 10, 5, 11, 7, 15, 14, 12, 8};
      logic [CH-1:0] eb;
      stoch = 1'b1;
      start = 1'b1;
      vals  = {4'd0, 4'd8, 4'd0, 4'd8};
      mode  = 1'b1;
      step();
      start = 1'b0;
      stoch = 1'b0;
      for (int i = 0; i < LEN; i++) begin
        step();
        eb = {1'b0, seq[i % 15] < 8, 1'b0, seq[i % 15] < 8};
        chk("stoch_bits", bits, eb);
      end
      step();
      chk("stoch_done", done, 1);
      step();
    end
`endif

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_assert, n_fail);
    $finish;
  end

endmodule
